// File: rtl/fp_unit_arbiter_if.sv
// fp_unit_arbiter_if: requester handshake, FP core operand/result, drain and statistics signals
interface fp_unit_arbiter_if #(parameter int NREQ = 4, parameter int W = 32);
  logic [NREQ-1:0] req_valid, req_ready, resp_valid;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [W-1:0] fpu_a, fpu_b, fpu_result, resp_data;
  logic drain_req, drain_done;
  logic [31:0] stat_issues, stat_conflicts;
  modport master(
    output req_valid, req_a, req_b, fpu_result, drain_req,
    input req_ready, fpu_a, fpu_b, resp_valid, resp_data, drain_done, stat_issues, stat_conflicts
  );
  modport slave(
    input req_valid, req_a, req_b, fpu_result, drain_req,
    output req_ready, fpu_a, fpu_b, resp_valid, resp_data, drain_done, stat_issues, stat_conflicts
  );
endinterface

// File: rtl/fp_unit_arbiter.sv
// fp_unit_arbiter: round-robin sharing of one fixed-latency FP core with tag-routed results.
// Define FPU_ARB_STATS_EN to build the issue/contention counters.
module fp_unit_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT = 12,
  parameter int W = 32
) (
  input logic clk,
  input logic rst,
  fp_unit_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  localparam logic [PW:0] NR = NREQ[PW:0];
  localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, DRAINED = 2'd2;
  logic [1:0] state;
  logic [PW-1:0] ptr, off, gid;
  logic [PW:0] sum;
  logic [NREQ-1:0] rot;
  logic any, issue, pipeBusy;
  logic [LAT:0] tagVld;
  logic [PW-1:0] tagId [LAT+1];
  // Rotate so that bit 0 is the requester the pointer currently favours
  assign rot = (bus.req_valid >> ptr) | (bus.req_valid << (NREQ - int'(ptr)));
  always_comb begin
    off = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) if (rot[k]) begin off = PW'(k); any = 1'b1; end
  end
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign gid = sum >= NR ? PW'(sum - NR) : sum[PW-1:0];
  assign issue = (state == RUN) & ~bus.drain_req & ~rst & any;
  assign bus.req_ready = issue ? NREQ'(1) << gid : '0;
  assign pipeBusy = |tagVld | issue;
  assign bus.drain_done = (state == DRAINED) & bus.drain_req;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      ptr <= '0;
      tagVld <= '0;
      bus.fpu_a <= '0;
      bus.fpu_b <= '0;
      bus.resp_valid <= '0;
      bus.resp_data <= '0;
    end else begin
      state <= state == RUN ? (bus.drain_req ? DRAIN : RUN)
             : state == DRAIN ? (pipeBusy ? DRAIN : DRAINED)
             : (bus.drain_req ? DRAINED : RUN);
      if (issue) ptr <= gid == PW'(NREQ - 1) ? '0 : gid + 1'b1;
      bus.fpu_a <= issue ? bus.req_a[gid*W +: W] : '0;
      bus.fpu_b <= issue ? bus.req_b[gid*W +: W] : '0;
      tagVld <= {tagVld[LAT-1:0], issue};
      bus.resp_valid <= tagVld[LAT] ? NREQ'(1) << tagId[LAT] : '0;
      if (tagVld[LAT]) bus.resp_data <= bus.fpu_result;
    end
  end
  always_ff @(posedge clk) begin
    tagId[0] <= gid;
    for (int s = 1; s <= LAT; s++) tagId[s] <= tagId[s-1];
  end
`ifdef FPU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.stat_issues <= '0;
      bus.stat_conflicts <= '0;
    end else begin
      if (issue) bus.stat_issues <= bus.stat_issues + 1'b1;
      if (state == RUN && |(bus.req_valid & (bus.req_valid - 1'b1))) bus.stat_conflicts <= bus.stat_conflicts + 1'b1;
    end
  end
`else
  assign bus.stat_issues = '0;
  assign bus.stat_conflicts = '0;
`endif
endmodule

// File: tb/tb_fp_unit_arbiter.sv
// tb_fp_unit_arbiter: randomized and directed checks of the arbiter against a queue-based reference model
module tb_fp_unit_arbiter;
  localparam int N = 4;
  localparam int LAT = 12;
`ifdef FPU_ARB_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  typedef struct {int due; int id; logic [31:0] data;} resp_t;
  logic clk = 0, rst = 1;
  int cyc = 0, checks = 0, failures = 0;
  fp_unit_arbiter_if #(.NREQ(N), .W(32)) bus();
  fp_unit_arbiter #(.NREQ(N), .LAT(LAT), .W(32)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Simplified positive-normal single-precision adder standing in for the shared core
  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] p, q;
    logic [7:0] d;
    logic [24:0] s, mq;
    if (x[30:23] >= y[30:23]) begin p = x; q = y; end else begin p = y; q = x; end
    d = p[30:23] - q[30:23];
    mq = d > 8'd24 ? 25'd0 : {2'b01, q[22:0]} >> d;
    s = {2'b01, p[22:0]} + mq;
    return s[24] ? {1'b0, p[30:23] + 8'd1, s[23:1]} : {1'b0, p[30:23], s[22:0]};
  endfunction
  function automatic logic [31:0] rndf();
    return {1'b0, 8'(100 + $urandom_range(0, 50)), 23'($urandom)};
  endfunction
  logic [31:0] core [LAT];
  always @(posedge clk) begin
    core[0] <= fadd(bus.fpu_a, bus.fpu_b);
    for (int k = 1; k < LAT; k++) core[k] <= core[k-1];
  end
  assign bus.fpu_result = core[LAT-1];
  resp_t expq[$];
  int mptr, egid, c0, lastresp;
  logic prev_dr, edd;
  logic [3:0] eg, erv;
  logic [31:0] efa, efb, erd, nfa, nfb, lastd;
  logic [104:0] obs, expv;
  assign obs = {bus.req_ready, bus.fpu_a, bus.fpu_b, bus.resp_valid, bus.resp_data, bus.drain_done};
  assign expv = {eg, efa, efb, erv, erd, edd};
  task automatic mreset();
    mptr = 0; expq.delete(); nfa = 0; nfb = 0; lastd = 0; prev_dr = 0; c0 = -100; lastresp = -100;
    eg = 0; erv = 0; efa = 0; efb = 0; erd = 0; edd = 0;
  endtask
  // Drive one cycle and derive every expected output of that cycle from the model
  task automatic apply(input logic [3:0] v, input logic dr, input logic rnd);
    logic en;
    @(posedge clk); #1;
    if (rnd) for (int i = 0; i < N; i++) begin bus.req_a[i*32 +: 32] = rndf(); bus.req_b[i*32 +: 32] = rndf(); end
    bus.req_valid = v;
    bus.drain_req = dr;
    if (dr && !prev_dr) c0 = cyc;
    en = !dr && !prev_dr;
    prev_dr = dr;
    egid = -1;
    if (en) for (int k = 0; k < N; k++) if (egid < 0 && v[(mptr + k) % N]) egid = (mptr + k) % N;
    eg = egid < 0 ? 4'd0 : 4'd1 << egid;
    efa = nfa; efb = nfb;
    erv = 0;
    if (expq.size() > 0 && expq[0].due == cyc) begin erv = 4'd1 << expq[0].id; lastd = expq[0].data; void'(expq.pop_front()); end
    erd = lastd;
    edd = dr && cyc >= c0 + 2 && cyc >= lastresp + 1;
    if (egid >= 0) begin
      nfa = bus.req_a[egid*32 +: 32]; nfb = bus.req_b[egid*32 +: 32];
      expq.push_back('{due: cyc + LAT + 2, id: egid, data: fadd(nfa, nfb)});
      lastresp = cyc + LAT + 2;
      mptr = (egid + 1) % N;
    end else begin nfa = 0; nfb = 0; end
  endtask
  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1; bus.req_valid = 0; bus.drain_req = 0;
    @(posedge clk); #1; rst = 0; mreset();
  endtask
  task automatic flush();
    for (int i = 0; i < LAT + 4; i++) begin
      apply(4'd0, 1'b0, 1'b1); @(negedge clk);
      checks++; if (obs !== expv) begin failures++; $display("FAIL flush_vec cyc=%0d got=%h exp=%h", cyc, obs, expv); end
    end
  endtask
  task automatic test_reset();
    rst = 1; bus.req_valid = '1; bus.drain_req = 0; bus.req_a = '0; bus.req_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'd0) begin failures++; $display("FAIL reset_ready got=%h exp=0", bus.req_ready); end
    checks++; if (bus.fpu_a !== 32'd0 || bus.fpu_b !== 32'd0) begin failures++; $display("FAIL reset_fpu got=%h/%h exp=0", bus.fpu_a, bus.fpu_b); end
    checks++; if (bus.resp_valid !== 4'd0) begin failures++; $display("FAIL reset_resp_valid got=%h exp=0", bus.resp_valid); end
    checks++; if (bus.resp_data !== 32'd0) begin failures++; $display("FAIL reset_resp_data got=%h exp=0", bus.resp_data); end
    checks++; if (bus.drain_done !== 1'b0) begin failures++; $display("FAIL reset_drain_done got=%b exp=0", bus.drain_done); end
    checks++; if (bus.stat_issues !== 32'd0 || bus.stat_conflicts !== 32'd0) begin failures++; $display("FAIL reset_stats got=%0d/%0d exp=0", bus.stat_issues, bus.stat_conflicts); end
    @(posedge clk); #1; rst = 0; bus.req_valid = 0; mreset();
  endtask
  task automatic test_directed();
    bus.req_a[32 +: 32] = 32'h3F800000; bus.req_b[32 +: 32] = 32'h40000000;
    apply(4'b0010, 1'b0, 1'b0); @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL directed_grant got=%h exp=2", bus.req_ready); end
    for (int i = 1; i <= LAT + 3; i++) begin
      apply(4'd0, 1'b0, 1'b1); @(negedge clk);
      checks++; if (obs !== expv) begin failures++; $display("FAIL directed_vec cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      if (i == 1) begin checks++; if (bus.fpu_a !== 32'h3F800000) begin failures++; $display("FAIL directed_fpu_a got=%h exp=3f800000", bus.fpu_a); end end
      if (i == LAT + 2) begin checks++; if (bus.resp_valid !== 4'b0010 || bus.resp_data !== 32'h40400000) begin failures++; $display("FAIL directed_resp got=%h/%h exp=2/40400000", bus.resp_valid, bus.resp_data); end end
      if (i == LAT + 3) begin checks++; if (bus.resp_valid !== 4'd0) begin failures++; $display("FAIL directed_pulse got=%h exp=0", bus.resp_valid); end end
    end
  endtask
  task automatic test_round_robin();
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      apply(4'hF, 1'b0, 1'b1); @(negedge clk);
      checks++; if (bus.req_ready !== 4'd1 << (i % N)) begin failures++; $display("FAIL rr_order i=%0d got=%h exp=%h", i, bus.req_ready, 4'd1 << (i % N)); end
      checks++; if (obs !== expv) begin failures++; $display("FAIL rr_vec cyc=%0d got=%h exp=%h", cyc, obs, expv); end
    end
    flush();
    checks++; if (bus.stat_conflicts !== 32'(STATS * 8)) begin failures++; $display("FAIL rr_conflicts got=%0d exp=%0d", bus.stat_conflicts, STATS * 8); end
    checks++; if (bus.stat_issues !== 32'(STATS * 8)) begin failures++; $display("FAIL rr_issues got=%0d exp=%0d", bus.stat_issues, STATS * 8); end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      apply(4'b1000, 1'b0, 1'b1); @(negedge clk);
      checks++; if (bus.req_ready !== 4'b1000) begin failures++; $display("FAIL b2b_grant i=%0d got=%h exp=8", i, bus.req_ready); end
      checks++; if (obs !== expv) begin failures++; $display("FAIL b2b_vec cyc=%0d got=%h exp=%h", cyc, obs, expv); end
    end
    apply(4'b0101, 1'b0, 1'b1); @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL b2b_wrap got=%h exp=1", bus.req_ready); end
    flush();
  endtask
  task automatic test_random();
    logic [3:0] hold;
    int wt [N];
    int worst;
    hold = 0; worst = 0;
    for (int i = 0; i < N; i++) wt[i] = 0;
    for (int n = 0; n < 200; n++) begin
      apply(hold | (4'($urandom) & 4'($urandom)), 1'b0, 1'b1); @(negedge clk);
      checks++; if (obs !== expv) begin failures++; $display("FAIL random_vec cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      for (int i = 0; i < N; i++) begin
        wt[i] = (bus.req_valid[i] && !bus.req_ready[i]) ? wt[i] + 1 : 0;
        if (wt[i] > worst) worst = wt[i];
      end
      hold = bus.req_valid & ~bus.req_ready;
    end
    checks++; if (worst > N - 1) begin failures++; $display("FAIL random_fairness got=%0d exp<=%0d", worst, N - 1); end
    flush();
  endtask
  task automatic test_drain();
    int seen;
    for (int i = 0; i < 3; i++) begin
      apply(4'b0001, 1'b0, 1'b1); @(negedge clk);
      checks++; if (obs !== expv) begin failures++; $display("FAIL drain_issue_vec cyc=%0d got=%h exp=%h", cyc, obs, expv); end
    end
    apply(4'hF, 1'b1, 1'b1); @(negedge clk);
    checks++; if (bus.req_ready !== 4'd0) begin failures++; $display("FAIL drain_ready got=%h exp=0", bus.req_ready); end
    seen = -1;
    for (int i = 0; i < 25 && seen < 0; i++) begin
      apply(4'hF, 1'b1, 1'b1); @(negedge clk);
      checks++; if (obs !== expv) begin failures++; $display("FAIL drain_vec cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      if (bus.drain_done) seen = cyc;
    end
    checks++; if (seen != lastresp + 1) begin failures++; $display("FAIL drain_done_cycle got=%0d exp=%0d", seen, lastresp + 1); end
    apply(4'hF, 1'b0, 1'b1); @(negedge clk);
    checks++; if (bus.drain_done !== 1'b0 || bus.req_ready !== 4'd0) begin failures++; $display("FAIL drain_release got=%b/%h exp=0/0", bus.drain_done, bus.req_ready); end
    apply(4'hF, 1'b0, 1'b1); @(negedge clk);
    checks++; if (obs !== expv || bus.req_ready === 4'd0) begin failures++; $display("FAIL drain_resume got=%h exp=%h", obs, expv); end
    flush();
  endtask
  task automatic test_reset_inflight();
    for (int i = 0; i < 5; i++) begin
      apply(4'hF, 1'b0, 1'b1); @(negedge clk);
      checks++; if (obs !== expv) begin failures++; $display("FAIL rstfl_issue_vec cyc=%0d got=%h exp=%h", cyc, obs, expv); end
    end
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      apply(4'd0, 1'b0, 1'b1); @(negedge clk);
      checks++; if (obs !== expv) begin failures++; $display("FAIL rstfl_vec cyc=%0d got=%h exp=%h", cyc, obs, expv); end
    end
    checks++; if (bus.stat_issues !== 32'd0 || bus.fpu_a !== 32'd0) begin failures++; $display("FAIL rstfl_state got=%0d/%h exp=0/0", bus.stat_issues, bus.fpu_a); end
  endtask
  task automatic test_idle();
    for (int i = 0; i < 30; i++) begin
      apply(4'd0, 1'b0, 1'b1); @(negedge clk);
      checks++; if (obs !== expv) begin failures++; $display("FAIL idle_vec cyc=%0d got=%h exp=%h", cyc, obs, expv); end
    end
  endtask
  initial begin
    mreset();
    test_reset();
    test_directed();
    test_round_robin();
    test_back_to_back();
    test_random();
    test_drain();
    test_idle();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
